// File: rtl/addr_gen_pkg.sv
// Shared types, default widths and a constant-safe clog2 for the
// multi-channel address generator.
package addr_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LEN_W  = 32;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_STRIDE = 1;

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/chan_word_counter.sv
// Channel/word position counter. Holds the position of the address
// currently presented and exposes the position that follows it, so the
// top can register the next address in the same cycle as the transfer.
module chan_word_counter
    import addr_gen_pkg::*;
#(
    parameter int LEN_W  = DEF_LEN_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [LEN_W-1:0] filesize,
    output logic [CH_W-1:0]  nxt_ch,
    output logic [LEN_W-1:0] nxt_word,
    output logic             is_last
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]  ch;
    logic [LEN_W-1:0] word;

    assign is_last = (word == (filesize - LEN_W'(1))) && (ch == LAST_CH);

    // Successor position: step the channel, roll to the next word after
    // the last channel, and wrap to the origin after the final word.
    always_comb begin
        nxt_ch   = ch + CH_W'(1);
        nxt_word = word;
        if (is_last) begin
            nxt_ch   = '0;
            nxt_word = '0;
        end else if (ch == LAST_CH) begin
            nxt_ch   = '0;
            nxt_word = word + LEN_W'(1);
        end
    end

    // Position register: cleared at the start of a pass, stepped per transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch   <= '0;
            word <= '0;
        end else if (clear) begin
            ch   <= '0;
            word <= '0;
        end else if (advance) begin
            ch   <= nxt_ch;
            word <= nxt_word;
        end
    end

endmodule

// File: rtl/multi_channel_address_gen.sv
// Round-robin multi-channel address sequencer with start/ready/valid
// handshake, circular mode, abort and a one-cycle done pulse.
// addr is registered; the next address is prepared from the counter's
// lookahead position so back-to-back transfers carry no bubbles.
module multi_channel_address_gen
    import addr_gen_pkg::*;
#(
    parameter  int ADDR_W = DEF_ADDR_W,
    parameter  int LEN_W  = DEF_LEN_W,
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int STRIDE = DEF_STRIDE,
    localparam int CH_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_CH*ADDR_W-1:0] offset,
    input  logic [LEN_W-1:0]         filesize,
    input  logic                     circular,
    input  logic                     abort,
    input  logic                     pause,
    input  logic                     addr_ready,
    output logic                     addr_valid,
    output logic [ADDR_W-1:0]        addr,
    output logic [CH_W-1:0]          addr_ch,
    output logic                     busy,
    output logic                     done
);

    localparam int SHIFT = clog2(STRIDE);
    localparam int NSLOT = 1 << CH_W;

    state_t state, state_d;

    logic [NSLOT*ADDR_W-1:0] offset_pad;
    logic [ADDR_W-1:0]       offset_q [NSLOT];
    logic [LEN_W-1:0]        filesize_q;
    logic                    circular_q;

    logic [CH_W-1:0]   nxt_ch;
    logic [LEN_W-1:0]  nxt_word;
    logic              is_last;
    logic              cnt_clear;
    logic              cnt_advance;
    logic              load_cfg;
    logic              xfer;

    logic              addr_valid_q, addr_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CH_W-1:0]   addr_ch_q, addr_ch_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] next_addr;

    // Base plus word index scaled by the power-of-two stride.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0]  w);
        return base + (ADDR_W'(w) << SHIFT);
    endfunction

    assign offset_pad = (NSLOT*ADDR_W)'(offset);
    assign start_addr = offset[ADDR_W-1:0];
    assign next_addr  = word_addr(offset_q[nxt_ch], nxt_word);
    assign xfer       = addr_valid_q & addr_ready;

    chan_word_counter #(
        .LEN_W  (LEN_W),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .advance  (cnt_advance),
        .filesize (filesize_q),
        .nxt_ch   (nxt_ch),
        .nxt_word (nxt_word),
        .is_last  (is_last)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-output logic; abort takes priority over completion.
    always_comb begin
        state_d      = state;
        addr_valid_d = addr_valid_q;
        addr_d       = addr_q;
        addr_ch_d    = addr_ch_q;
        done_d       = 1'b0;
        load_cfg     = 1'b0;
        cnt_clear    = 1'b0;
        cnt_advance  = 1'b0;
        case (state)
            IDLE: begin
                addr_valid_d = 1'b0;
                if (start) begin
                    if (filesize != '0) begin
                        state_d      = RUN;
                        load_cfg     = 1'b1;
                        cnt_clear    = 1'b1;
                        addr_d       = start_addr;
                        addr_ch_d    = '0;
                        addr_valid_d = ~pause;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d      = IDLE;
                    addr_valid_d = 1'b0;
                    done_d       = 1'b1;
                end else if (xfer) begin
                    if (is_last && !circular_q) begin
                        state_d      = IDLE;
                        addr_valid_d = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        cnt_advance  = 1'b1;
                        addr_d       = next_addr;
                        addr_ch_d    = nxt_ch;
                        addr_valid_d = ~pause;
                    end
                end else if (!addr_valid_q && !pause) begin
                    addr_valid_d = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                addr_valid_d = 1'b0;
            end
        endcase
    end

    // Pass configuration captured at start; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSLOT; k++) begin
                offset_q[k] <= '0;
            end
            filesize_q <= '0;
            circular_q <= 1'b0;
        end else if (load_cfg) begin
            for (int k = 0; k < NSLOT; k++) begin
                offset_q[k] <= offset_pad[k*ADDR_W +: ADDR_W];
            end
            filesize_q <= filesize;
            circular_q <= circular;
        end
    end

    // Registered handshake and address outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_valid_q <= 1'b0;
            addr_q       <= '0;
            addr_ch_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            addr_valid_q <= addr_valid_d;
            addr_q       <= addr_d;
            addr_ch_q    <= addr_ch_d;
            done_q       <= done_d;
        end
    end

    assign addr_valid = addr_valid_q;
    assign addr       = addr_q;
    assign addr_ch    = addr_ch_q;
    assign done       = done_q;
    assign busy       = (state == RUN);

endmodule

// File: tb/tb_multi_channel_address_gen.sv
// Directed self-checking bench for multi_channel_address_gen.
// Instance "dut" is two-channel unit-stride; "dut1" is single-channel
// stride-4 for the address wrap-around case.
module tb_multi_channel_address_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        start;
    logic [63:0] offset;
    logic [31:0] filesize;
    logic        circular;
    logic        abort;
    logic        pause;
    logic        addr_ready;
    logic        addr_valid;
    logic [31:0] addr;
    logic        addr_ch;
    logic        busy;
    logic        done;

    logic        b_start;
    logic [31:0] b_offset;
    logic [31:0] b_filesize;
    logic        b_valid;
    logic [31:0] b_addr;
    logic        b_ch;
    logic        b_busy;
    logic        b_done;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp1 [6] = '{32'h100, 32'h800, 32'h101, 32'h801, 32'h102, 32'h802};
    logic [31:0] exp3 [4] = '{32'h100, 32'h800, 32'h101, 32'h801};
    localparam logic [63:0] OFFS = 64'h0000_0800_0000_0100;

    multi_channel_address_gen #(
        .ADDR_W (32), .LEN_W (32), .NUM_CH (2), .STRIDE (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .offset     (offset),
        .filesize   (filesize),
        .circular   (circular),
        .abort      (abort),
        .pause      (pause),
        .addr_ready (addr_ready),
        .addr_valid (addr_valid),
        .addr       (addr),
        .addr_ch    (addr_ch),
        .busy       (busy),
        .done       (done)
    );

    multi_channel_address_gen #(
        .ADDR_W (32), .LEN_W (32), .NUM_CH (1), .STRIDE (4)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (b_start),
        .offset     (b_offset),
        .filesize   (b_filesize),
        .circular   (1'b0),
        .abort      (1'b0),
        .pause      (1'b0),
        .addr_ready (1'b1),
        .addr_valid (b_valid),
        .addr       (b_addr),
        .addr_ch    (b_ch),
        .busy       (b_busy),
        .done       (b_done)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Load a pass configuration on the main instance and pulse start for one edge.
    task automatic applyStimulus(input logic [63:0] off, input logic [31:0] fs, input logic circ);
        offset   = off;
        filesize = fs;
        circular = circ;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int          idx;
        logic        prev_valid, prev_ready, prev_pause;
        logic [31:0] prev_addr;

        rst_n = 1'b0;
        start = 0; offset = '0; filesize = '0; circular = 0;
        abort = 0; pause = 0; addr_ready = 1;
        b_start = 0; b_offset = '0; b_filesize = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", addr_valid, 0);
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_ch", addr_ch, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // Basic two-channel pass, ready held high
        $display("[TB] basic pass");
        applyStimulus(OFFS, 3, 0);
        for (int i = 0; i < 6; i++) begin
            checkOutput("t1_addr", addr, exp1[i]);
            checkOutput("t1_ch", addr_ch, i % 2);
            checkOutput("t1_valid", addr_valid, 1);
            checkOutput("t1_busy", busy, 1);
            checkOutput("t1_done_low", done, 0);
            tick();
        end
        checkOutput("t1_done", done, 1);
        checkOutput("t1_busy_end", busy, 0);
        checkOutput("t1_valid_end", addr_valid, 0);
        tick();
        checkOutput("t1_done_once", done, 0);

        // Random ready with pause pulses
        $display("[TB] ready/pause pass");
        idx        = 0;
        pause      = 1'b1;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_pause = 1'b1;
        prev_addr  = '0;
        applyStimulus(OFFS, 3, 0);
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (addr_valid && !prev_valid)
                checkOutput("t2_rise_pause", prev_pause, 0);
            if (prev_valid && !prev_ready) begin
                checkOutput("t2_hold", addr_valid, 1);
                checkOutput("t2_stable", addr, prev_addr);
            end
            if (addr_valid) begin
                if (idx < 6) begin
                    checkOutput("t2_addr", addr, exp1[idx]);
                    checkOutput("t2_ch", addr_ch, idx % 2);
                end else begin
                    checkOutput("t2_extra_valid", addr_valid, 0);
                end
            end
            addr_ready = 1'($urandom_range(0, 1));
            pause      = (cyc % 5 == 1) || (cyc % 7 == 3);
            if (addr_valid && addr_ready) idx++;
            prev_valid = addr_valid;
            prev_ready = addr_ready;
            prev_pause = pause;
            prev_addr  = addr;
            tick();
        end
        checkOutput("t2_count", idx, 6);
        checkOutput("t2_done", done, 1);
        checkOutput("t2_busy_end", busy, 0);
        addr_ready = 1'b1;
        pause      = 1'b0;
        tick();

        // Circular mode, 10 transfers, then abort
        $display("[TB] circular pass");
        applyStimulus(OFFS, 2, 1);
        for (int k = 0; k < 10; k++) begin
            checkOutput("t3_addr", addr, exp3[k % 4]);
            checkOutput("t3_valid", addr_valid, 1);
            checkOutput("t3_no_done", done, 0);
            tick();
        end
        checkOutput("t3_addr11", addr, 32'h101);
        addr_ready = 1'b0;
        abort      = 1'b1;
        tick();
        abort      = 1'b0;
        addr_ready = 1'b1;
        checkOutput("t3_abort_done", done, 1);
        checkOutput("t3_abort_busy", busy, 0);
        checkOutput("t3_abort_valid", addr_valid, 0);
        tick();
        checkOutput("t3_done_once", done, 0);
        checkOutput("t3_idle", busy, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t3_idle_abort_done", done, 0);
        checkOutput("t3_idle_abort_busy", busy, 0);

        // Zero-length start
        $display("[TB] zero-length start");
        applyStimulus(OFFS, 0, 0);
        checkOutput("t4_valid", addr_valid, 0);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_done", done, 1);
        tick();
        checkOutput("t4_done_once", done, 0);

        // Address wrap-around on the single-channel stride-4 instance
        $display("[TB] wrap-around");
        b_offset   = 32'hFFFF_FFFE;
        b_filesize = 2;
        b_start    = 1'b1;
        tick();
        b_start    = 1'b0;
        checkOutput("t5_addr0", b_addr, 32'hFFFF_FFFE);
        checkOutput("t5_valid", b_valid, 1);
        checkOutput("t5_ch", b_ch, 0);
        tick();
        checkOutput("t5_addr1", b_addr, 32'h0000_0002);
        tick();
        checkOutput("t5_done", b_done, 1);
        checkOutput("t5_busy", b_busy, 0);

        // Reset in the middle of a pass
        $display("[TB] mid-pass reset");
        applyStimulus(OFFS, 3, 0);
        tick();
        checkOutput("t6_pre_addr", addr, 32'h800);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_valid", addr_valid, 0);
        checkOutput("t6_addr", addr, 0);
        checkOutput("t6_ch", addr_ch, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("t6_no_done", done, 0);
        applyStimulus(OFFS, 3, 0);
        checkOutput("t6_restart_addr", addr, 32'h100);
        checkOutput("t6_restart_ch", addr_ch, 0);
        checkOutput("t6_restart_valid", addr_valid, 1);
        tick();
        checkOutput("t6_second_addr", addr, 32'h800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
